if_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the execute stage.
- Owns the PC and issues in-order fetch requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned words in a small in-order queue and presents them to execute as inst/inst_addr with valid/ready.
- Redirects on the execute stage's pc_jump/pc_jump_addr and discards all wrong-path words, buffered and in flight.

---
 rtl/if_fetch_unit.sv | 95 +++++++++
 tb/tb_if_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with in-order queue and redirect
// Owns the PC, issues fetches, buffers in-order responses, drops wrong-path words.
module if_fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_ADDR = '0,
   parameter int              DEPTH      = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_jump,
   input  logic [XLEN-1:0] pc_jump_addr,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_addr
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int QN = 1 << PW;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] q_data [QN];
   logic [XLEN-1:0] q_addr [QN];
   logic [PW-1:0]   q_head, q_tail;
   logic [CW-1:0]   q_count;
   // PCs of issued requests, popped one per response (kept or dropped)
   logic [XLEN-1:0] f_addr [QN];
   logic [PW-1:0]   f_head, f_tail;
   logic [CW-1:0]   outstanding, drop_cnt, outstanding_next;
   logic [CW:0]     credit_used;
   logic            req_fire, resp_fire, push, pop;
   logic            unused_bits;

   assign unused_bits      = ^pc_jump_addr[1:0];
   assign credit_used      = {1'b0, q_count} + {1'b0, outstanding};
   assign imem_req_valid   = !rst && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr    = pc;
   assign req_fire         = imem_req_valid && imem_req_ready;
   assign resp_fire        = imem_resp_valid && (outstanding != '0);
   assign push             = resp_fire && (drop_cnt == '0);
   assign inst_valid       = (q_count != '0);
   assign pop              = inst_valid && inst_ready;
   assign inst             = inst_valid ? q_data[q_head] : NOP;
   assign inst_addr        = inst_valid ? q_addr[q_head] : '0;
   assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_ADDR;
         q_head      <= '0;
         q_tail      <= '0;
         q_count     <= '0;
         f_head      <= '0;
         f_tail      <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         assert (credit_used <= (CW+1)'(DEPTH));
         assert (drop_cnt <= outstanding);
         outstanding <= outstanding_next;
         if (req_fire)  f_tail <= f_tail + PW'(1);
         if (resp_fire) f_head <= f_head + PW'(1);
         if (pc_jump) begin
            // every request still in flight after this edge belongs to the old path
            pc       <= {pc_jump_addr[XLEN-1:2], 2'b00};
            q_head   <= '0;
            q_tail   <= '0;
            q_count  <= '0;
            drop_cnt <= outstanding_next;
         end else begin
            if (req_fire) pc <= pc + XLEN'(4);
            if (push)     q_tail <= q_tail + PW'(1);
            if (pop)      q_head <= q_head + PW'(1);
            q_count <= q_count + CW'(push) - CW'(pop);
            if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && req_fire) f_addr[f_tail] <= pc;
      if (!rst && !pc_jump && push) begin
         q_data[q_tail] <= imem_resp_data;
         q_addr[q_tail] <= f_addr[f_head];
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit
// In-order memory model plus a "next expected address" view of the delivered stream.
module tb_if_fetch_unit;

   localparam int          XLEN       = 32;
   localparam int          DEPTH      = 2;
   localparam logic [31:0] RESET_ADDR = 32'h0;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_jump = 1'b0;
   logic [31:0] pc_jump_addr = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_addr;

   if_fetch_unit #(.XLEN(XLEN), .RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_jump(pc_jump), .pc_jump_addr(pc_jump_addr),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_addr(inst_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          rand_req_ready = 1'b0;
   int          last_due = 0;
   int          max_out = 0;
   int          first_valid_cyc = -1;
   pend_t       pend[$];
   logic [31:0] exp_pc = RESET_ADDR;
   logic [31:0] exp_req = RESET_ADDR;
   logic [31:0] pop_addr[$];
   int          pop_cyc[$];
   logic [31:0] fire_addr[$];
   int          fire_cyc[$];

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // One clock cycle: memory model drives, outputs are scored, then the edge passes.
   task automatic cycle();
      int    n_out;
      pend_t p;
      n_out = pend.size();
      if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memword(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom();
      end
      if (rand_req_ready) imem_req_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!inst_valid) begin
         total++;
         if (inst !== NOP || inst_addr !== 32'h0) begin
            bad++;
            $display("FAIL idle_outputs: got inst=%h addr=%h want %h/0", inst, inst_addr, NOP);
         end
      end
      total++;
      if (imem_req_valid && n_out >= DEPTH) begin
         bad++;
         $display("FAIL credit: req_valid=1 with %0d outstanding, want <%0d", n_out, DEPTH);
      end
      if (rst) begin
         pend.delete();
         last_due = 0;
         exp_pc   = RESET_ADDR;
         exp_req  = RESET_ADDR;
      end else begin
         if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (inst_valid && inst_ready) begin
            total++;
            if (inst_addr !== exp_pc || inst !== memword(exp_pc)) begin
               bad++;
               $display("FAIL deliver: got %h@%h want %h@%h", inst, inst_addr, memword(exp_pc), exp_pc);
            end
            pop_addr.push_back(inst_addr);
            pop_cyc.push_back(cyc);
            exp_pc += 32'd4;
         end
         if (imem_req_valid && imem_req_ready) begin
            total++;
            if (imem_req_addr !== exp_req) begin
               bad++;
               $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_req);
            end
            fire_addr.push_back(imem_req_addr);
            fire_cyc.push_back(cyc);
            p.addr = imem_req_addr;
            p.due  = cyc + $urandom_range(lat_min, lat_max);
            if (p.due <= last_due) p.due = last_due + 1;
            last_due = p.due;
            pend.push_back(p);
            if (pend.size() > max_out) max_out = pend.size();
            exp_req += 32'd4;
         end
         if (pc_jump) begin
            exp_pc  = {pc_jump_addr[31:2], 2'b00};
            exp_req = {pc_jump_addr[31:2], 2'b00};
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      pc_jump = 1'b0;
      repeat (n) cycle();
      rst = 1'b0;
      pop_addr.delete();
      pop_cyc.delete();
      fire_addr.delete();
      fire_cyc.delete();
      first_valid_cyc = -1;
      max_out = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      total++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: got rv=%b iv=%b inst=%h addr=%h want 0 0 %h 0",
                  imem_req_valid, inst_valid, inst, inst_addr, NOP);
      end
      cycle();
      rst = 1'b0;
      #1;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_ADDR) begin
         bad++;
         $display("FAIL reset_release: got rv=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RESET_ADDR);
      end
   endtask

   task automatic test_basic();
      lat_min = 1; lat_max = 1; rand_req_ready = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset(2);
      for (int i = 0; i < 20 && pop_addr.size() < 4; i++) cycle();
      total++;
      if (pop_addr.size() < 2) begin
         bad++;
         $display("FAIL basic_progress: got %0d pops want >=2", pop_addr.size());
      end else begin
         total++;
         if (pop_addr[0] !== 32'h0 || pop_addr[1] !== 32'h4 || pop_cyc[1] != pop_cyc[0] + 1) begin
            bad++;
            $display("FAIL basic_order: got %h,%h gap %0d want 0,4 gap 1", pop_addr[0], pop_addr[1], pop_cyc[1] - pop_cyc[0]);
         end
         total++;
         if (first_valid_cyc - fire_cyc[0] != 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 2", first_valid_cyc - fire_cyc[0]);
         end
      end
      total++;
      if (max_out > 2) begin
         bad++;
         $display("FAIL basic_outstanding: got %0d want <=2", max_out);
      end
   endtask

   task automatic test_backpressure();
      lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
      do_reset(1);
      repeat (10) cycle();
      total++;
      if (fire_addr.size() != 2 || fire_addr[0] !== 32'h0 || fire_addr[1] !== 32'h4) begin
         bad++;
         $display("FAIL bp_requests: got %0d requests want 2 (0x0,0x4)", fire_addr.size());
      end
      total++;
      if (imem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_stall: got req_valid=%b want 0", imem_req_valid);
      end
      inst_ready = 1'b1;
      for (int i = 0; i < 30 && pop_addr.size() < 3; i++) cycle();
      total++;
      if (pop_addr.size() < 3 || pop_addr[0] !== 32'h0 || pop_addr[1] !== 32'h4 || pop_addr[2] !== 32'h8) begin
         bad++;
         $display("FAIL bp_drain: got %0d pops want 0x0,0x4,0x8", pop_addr.size());
      end
   endtask

   task automatic test_redirect();
      lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset(1);
      for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
      total++;
      if (pend.size() != 2) begin
         bad++;
         $display("FAIL redir_setup: got %0d outstanding want 2", pend.size());
      end
      pc_jump = 1'b1;
      pc_jump_addr = 32'h0000_0103;
      fire_addr.delete();
      pop_addr.delete();
      cycle();
      pc_jump = 1'b0;
      for (int i = 0; i < 30 && pop_addr.size() < 1; i++) cycle();
      total++;
      if (fire_addr.size() < 1 || fire_addr[0] !== 32'h100 || pop_addr.size() < 1 || pop_addr[0] !== 32'h100) begin
         bad++;
         $display("FAIL redir_target: got %0d reqs %0d pops want first req and pop at 0x100",
                  fire_addr.size(), pop_addr.size());
      end
   endtask

   // Redirect on cycles where two of handshake / response / pop coincide.
   task automatic test_collide();
      bit hit;
      bit rsp, fire, pp;
      lat_min = 1; lat_max = 3; rand_req_ready = 1'b0; imem_req_ready = 1'b1;
      for (int mode = 0; mode < 3; mode++) begin
         do_reset(1);
         hit = 1'b0;
         for (int i = 0; i < 2000 && !hit; i++) begin
            inst_ready = $urandom_range(0, 1);
            #0;
            rsp  = pend.size() > 0 && pend[0].due <= cyc;
            fire = imem_req_valid;
            pp   = inst_valid && inst_ready;
            hit  = (mode == 0) ? (rsp && fire) : (mode == 1) ? (rsp && pp) : (fire && pp);
            pc_jump = hit;
            pc_jump_addr = $urandom();
            cycle();
            pc_jump = 1'b0;
         end
         total++;
         if (!hit) begin
            bad++;
            $display("FAIL collide_reach: mode %0d got no coincidence want one", mode);
         end else begin
            total++;
            if (inst_valid !== 1'b0 || imem_req_valid !== (pend.size() < DEPTH)) begin
               bad++;
               $display("FAIL collide_after: mode %0d got iv=%b rv=%b want iv=0 rv=%b",
                        mode, inst_valid, imem_req_valid, pend.size() < DEPTH);
            end
         end
         inst_ready = 1'b1;
         repeat (20) cycle();
      end
   endtask

   task automatic test_wrap();
      lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset(1);
      pc_jump = 1'b1;
      pc_jump_addr = 32'hFFFF_FFFC;
      cycle();
      pc_jump = 1'b0;
      pop_addr.delete();
      for (int i = 0; i < 30 && pop_addr.size() < 2; i++) cycle();
      total++;
      if (pop_addr.size() < 2 || pop_addr[0] !== 32'hFFFF_FFFC || pop_addr[1] !== 32'h0) begin
         bad++;
         $display("FAIL wrap: got %0d pops want 0xfffffffc then 0x0", pop_addr.size());
      end
   endtask

   task automatic test_reset_mid();
      lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset(1);
      pc_jump = 1'b1;
      pc_jump_addr = 32'h0000_0400;
      cycle();
      pc_jump = 1'b0;
      for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
      rst = 1'b1;
      cycle();
      total++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h0) begin
         bad++;
         $display("FAIL midreset_state: got rv=%b iv=%b inst=%h addr=%h want 0 0 %h 0",
                  imem_req_valid, inst_valid, inst, inst_addr, NOP);
      end
      cycle();
      rst = 1'b0;
      fire_addr.delete();
      pop_addr.delete();
      for (int i = 0; i < 20 && pop_addr.size() < 1; i++) cycle();
      total++;
      if (fire_addr.size() < 1 || fire_addr[0] !== RESET_ADDR || pop_addr.size() < 1 || pop_addr[0] !== RESET_ADDR) begin
         bad++;
         $display("FAIL midreset_restart: got %0d reqs %0d pops want first at %h",
                  fire_addr.size(), pop_addr.size(), RESET_ADDR);
      end
   endtask

   task automatic test_random();
      lat_min = 1; lat_max = 4; rand_req_ready = 1'b1;
      do_reset(1);
      for (int i = 0; i < 1500; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         pc_jump = ($urandom_range(0, 39) == 0);
         pc_jump_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
         cycle();
      end
      pc_jump = 1'b0;
      rand_req_ready = 1'b0;
      imem_req_ready = 1'b1;
      total++;
      if (pop_addr.size() < 50) begin
         bad++;
         $display("FAIL random_progress: got %0d pops want >=50", pop_addr.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect();
      test_collide();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
